// File: rtl/sync_fifo_write_arbiter.sv
// Round-robin arbiter that merges NUM_REQ requester streams into one FIFO write port.
// Grants are held for up to MAX_BURST transfers and revoked after STALL_LIMIT full cycles.
module sync_fifo_write_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 4,
    parameter int STALL_LIMIT = 8,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic                          fifo_full_in,
    output logic                          fifo_wr_en_out,
    output logic [DATA_WIDTH-1:0]         fifo_data_out,
    output logic [NUM_REQ-1:0]            grant_out,
    output logic [IDW-1:0]                grant_id_out,
    output logic                          preempt_out
);

    typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

    state_t               state, state_nx;
    logic [NUM_REQ-1:0]   grant_nx;
    logic [IDW-1:0]       gid_nx, last_id, last_id_nx;
    logic [7:0]           burst_cnt, burst_nx, stall_cnt, stall_nx;
    logic                 preempt_nx;
    logic [IDW-1:0]       sel_id;
    logic                 sel_vld;
    logic                 gnt_vld;
    int                   arb_idx;

    // Round-robin search starting just past the last grantee.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        arb_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = (int'(last_id) + 1 + i) % NUM_REQ;
            if (!sel_vld && req_valid_in[arb_idx]) begin
                sel_vld = 1'b1;
                sel_id  = IDW'(arb_idx);
            end
        end
    end

    assign gnt_vld        = req_valid_in[grant_id_out];
    assign req_ready_out  = (state == GRANT && !fifo_full_in) ? grant_out : '0;
    assign fifo_wr_en_out = |(req_valid_in & req_ready_out);
    assign fifo_data_out  = (|grant_out)
                          ? req_data_in[int'(grant_id_out)*DATA_WIDTH +: DATA_WIDTH]
                          : '0;

    always_comb begin
        state_nx   = state;
        grant_nx   = grant_out;
        gid_nx     = grant_id_out;
        last_id_nx = last_id;
        burst_nx   = burst_cnt;
        stall_nx   = stall_cnt;
        preempt_nx = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_nx   = GRANT;
                    grant_nx   = NUM_REQ'(1) << sel_id;
                    gid_nx     = sel_id;
                    last_id_nx = sel_id;
                    burst_nx   = '0;
                    stall_nx   = '0;
                end
            end
            GRANT: begin
                // Valid drop releases even when the FIFO is full.
                if (!gnt_vld) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end else if (fifo_full_in) begin
                    state_nx = STALL;
                    stall_nx = 8'd1;
                end else begin
                    burst_nx = burst_cnt + 8'd1;
                    if (burst_cnt + 8'd1 >= 8'(MAX_BURST)) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                    end
                end
            end
            STALL: begin
                if (!gnt_vld) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end else if (!fifo_full_in) begin
                    state_nx = GRANT;
                    stall_nx = '0;
                end else begin
                    stall_nx = stall_cnt + 8'd1;
                    if (stall_cnt + 8'd1 >= 8'(STALL_LIMIT)) begin
                        state_nx   = IDLE;
                        grant_nx   = '0;
                        preempt_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            grant_out    <= '0;
            grant_id_out <= '0;
            last_id      <= IDW'(NUM_REQ - 1);
            burst_cnt    <= '0;
            stall_cnt    <= '0;
            preempt_out  <= 1'b0;
        end else begin
            state        <= state_nx;
            grant_out    <= grant_nx;
            grant_id_out <= gid_nx;
            last_id      <= last_id_nx;
            burst_cnt    <= burst_nx;
            stall_cnt    <= stall_nx;
            preempt_out  <= preempt_nx;
        end
    end

endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// Scoreboard bench: requester models feed queued words, expected writes and grants
// are queued in predicted order and compared as the arbiter emits them.
module tb_sync_fifo_write_arbiter;
    localparam int DW = 64;
    localparam int NR = 4;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic [NR-1:0]      req_valid_in = '0;
    logic [NR*DW-1:0]   req_data_in = '0;
    logic [NR-1:0]      req_ready_out;
    logic               fifo_full_in;
    logic               fifo_wr_en_out;
    logic [DW-1:0]      fifo_data_out;
    logic [NR-1:0]      grant_out;
    logic [1:0]         grant_id_out;
    logic               preempt_out;

    sync_fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4), .STALL_LIMIT(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_ready_out(req_ready_out),
        .fifo_full_in(fifo_full_in), .fifo_wr_en_out(fifo_wr_en_out), .fifo_data_out(fifo_data_out),
        .grant_out(grant_out), .grant_id_out(grant_id_out), .preempt_out(preempt_out)
    );

    always #5 clk_in = ~clk_in;

    logic [63:0] src [NR][$];
    logic [63:0] exp_q[$];
    int          gnt_q[$];
    int          gcyc_q[$];
    logic [NR-1:0] took = '0;
    logic [NR-1:0] prev_g = '0;
    int cyc = 0, nwr = 0, npre = 0;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Requester models: pop on the handshake seen last cycle, then present the next word.
    always @(posedge clk_in) begin
        #2;
        for (int i = 0; i < NR; i++) begin
            if (took[i] && src[i].size() > 0) void'(src[i].pop_front());
            req_valid_in[i]          = (src[i].size() > 0);
            req_data_in[i*DW +: DW]  = (src[i].size() > 0) ? src[i][0] : '0;
        end
    end

    always @(negedge clk_in) begin
        for (int i = 0; i < NR; i++) took[i] = req_valid_in[i] & req_ready_out[i] & ~rst_in;
        if (!rst_in) begin
            if (fifo_wr_en_out) begin
                nwr++;
                chk("wr_while_full", fifo_full_in, 0);
                if (exp_q.size() == 0) chk("wr_unexpected", exp_q.size(), 1);
                else chk("wdata", fifo_data_out, exp_q.pop_front());
            end
            if (grant_out != prev_g && grant_out != '0) begin
                gcyc_q.push_back(cyc);
                if (gnt_q.size() == 0) chk("gnt_unexpected", gnt_q.size(), 1);
                else begin
                    int e;
                    e = gnt_q.pop_front();
                    chk("gnt_id", grant_id_out, e);
                    chk("gnt_onehot", grant_out, 64'(1) << e);
                end
            end
            if (preempt_out) npre++;
        end
        prev_g = grant_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic load_src(input int id, input logic [63:0] base, input int n, input bit to_exp);
        for (int k = 0; k < n; k++) begin
            src[id].push_back(base + 64'(k));
            if (to_exp) exp_q.push_back(base + 64'(k));
        end
    endtask

    function automatic bit src_busy();
        bit b = 0;
        for (int i = 0; i < NR; i++) if (src[i].size() > 0) b = 1;
        return b;
    endfunction

    task automatic wait_wr(input int target, input string tag);
        int t = 0;
        while (nwr < target && t < 500) begin
            @(posedge clk_in);
            t++;
        end
        chk(tag, (nwr >= target), 1);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || grant_out != '0 || src_busy()) && t < 300) begin
            tick(1);
            t++;
        end
        chk({tag, "_exp_left"}, exp_q.size(), 0);
        chk({tag, "_gnt_left"}, gnt_q.size(), 0);
    endtask

    initial begin
        int base, pre0, t;
        rst_in = 1'b1;
        fifo_full_in = 1'b0;
        tick(2);

        // Outputs quiet while reset is held, even with a requester valid.
        load_src(0, 64'h55, 1, 0);
        tick(2);
        chk("rst_wr_en", fifo_wr_en_out, 0);
        chk("rst_ready", req_ready_out, 0);
        chk("rst_data", fifo_data_out, 0);
        chk("rst_grant", grant_out, 0);
        chk("rst_gid", grant_id_out, 0);
        chk("rst_preempt", preempt_out, 0);
        src[0].delete();
        tick(2);
        rst_in = 1'b0;
        tick(1);

        // Single requester 2: two bursts (4 + 2) separated by one IDLE cycle.
        gcyc_q.delete();
        base = nwr;
        load_src(2, 64'hA0, 6, 1);
        gnt_q.push_back(2); gnt_q.push_back(2);
        t = cyc;
        drain("single");
        chk("single_nwr", nwr - base, 6);
        if (gcyc_q.size() == 2) begin
            chk("single_lat", gcyc_q[0] - t, 1);
            chk("single_gap", gcyc_q[1] - gcyc_q[0], 5);
        end else chk("single_ngnt", gcyc_q.size(), 2);

        // Round robin from reset: all four valid, two full rotations.
        rst_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
        gcyc_q.delete();
        base = nwr;
        for (int i = 0; i < NR; i++) load_src(i, 64'h1000 * (i + 1), 8, 0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) begin
                gnt_q.push_back(i);
                for (int k = 0; k < 4; k++) exp_q.push_back(64'h1000 * (i + 1) + 64'(r * 4 + k));
            end
        drain("rr");
        chk("rr_nwr", nwr - base, 32);
        if (gcyc_q.size() == 8) begin
            for (int g = 1; g < 8; g++) chk("rr_period", gcyc_q[g] - gcyc_q[g-1], 5);
        end else chk("rr_ngnt", gcyc_q.size(), 8);

        // Full stall mid-burst: burst count survives, so 6 words take two grants.
        base = nwr;
        load_src(1, 64'hB0, 6, 1);
        gnt_q.push_back(1); gnt_q.push_back(1);
        wait_wr(base + 2, "stall_wait");
        #1 fifo_full_in = 1'b1;
        #1;
        chk("stall_ready0", req_ready_out, 0);
        chk("stall_wr0", fifo_wr_en_out, 0);
        tick(1);
        chk("stall_ready1", req_ready_out, 0);
        chk("stall_grant_held", grant_out, 4'b0010);
        tick(2);
        chk("stall_nwr_frozen", nwr - base, 2);
        fifo_full_in = 1'b0;
        drain("stall");
        chk("stall_nwr", nwr - base, 6);

        // Preemption of req 3 after 8 full cycles, then req 0 is served.
        base = nwr;
        pre0 = npre;
        load_src(3, 64'hC0, 4, 0);
        load_src(0, 64'hD0, 4, 1);
        for (int k = 0; k < 4; k++) exp_q.push_back(64'hC0 + 64'(k));
        gnt_q.push_back(3); gnt_q.push_back(0); gnt_q.push_back(3);
        t = 0;
        while (grant_out != 4'b1000 && t < 50) begin
            tick(1);
            t++;
        end
        chk("pre_wait", (t < 50), 1);
        fifo_full_in = 1'b1;
        tick(7);
        chk("pre_early", preempt_out, 0);
        chk("pre_held", grant_out, 4'b1000);
        tick(1);
        chk("pre_pulse", preempt_out, 1);
        chk("pre_clear", grant_out, 0);
        fifo_full_in = 1'b0;
        tick(1);
        chk("pre_pulse_end", preempt_out, 0);
        chk("pre_next0", grant_out, 4'b0001);
        drain("pre");
        chk("pre_count", npre - pre0, 1);
        chk("pre_nwr", nwr - base, 8);

        // Reset during req 1's burst after two writes.
        base = nwr;
        load_src(1, 64'hE0, 4, 0);
        exp_q.push_back(64'hE0); exp_q.push_back(64'hE1);
        gnt_q.push_back(1);
        wait_wr(base + 2, "rst_wait");
        #3;
        chk("rst_mid_pre", fifo_wr_en_out, 1);
        rst_in = 1'b1;
        #1;
        chk("rst_mid_wr", fifo_wr_en_out, 0);
        chk("rst_mid_grant", grant_out, 0);
        chk("rst_mid_exp", exp_q.size(), 0);
        for (int i = 0; i < NR; i++) src[i].delete();
        tick(2);
        load_src(0, 64'hF0, 2, 1);
        load_src(1, 64'hF8, 2, 1);
        gnt_q.push_back(0); gnt_q.push_back(1);
        rst_in = 1'b0;
        drain("rst_mid");
        chk("rst_mid_nwr", nwr - base, 6);

        // Req 0 drops valid after two transfers: released, no preempt.
        base = nwr;
        pre0 = npre;
        load_src(0, 64'h70, 2, 1);
        gnt_q.push_back(0);
        wait_wr(base + 2, "drop_wait");
        @(posedge clk_in);
        #1;
        chk("drop_release", grant_out, 0);
        chk("drop_preempt", preempt_out, 0);
        drain("drop");
        chk("drop_nwr", nwr - base, 2);
        chk("drop_npre", npre - pre0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/sync_fifo_write_arbiter.md
SYNC_FIFO_WRITE_ARBITER -- requirements
Module: sync_fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64: width of each requester data word and of the FIFO write data.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..16.
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum transfers per grant, range 1..255.
REQ-004 The block SHALL have parameter STALL_LIMIT, default 8: consecutive full cycles before grant preemption, range 1..255.
REQ-005 The block SHALL have port clk_in, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port req_valid_in, input, NUM_REQ bits: per-requester data valid.
REQ-008 The block SHALL have port req_data_in, input, NUM_REQ*DATA_WIDTH bits: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port req_ready_out, output, NUM_REQ bits: per-requester accept.
REQ-010 The block SHALL have port fifo_full_in, input, 1 bit: FIFO full flag.
REQ-011 The block SHALL have port fifo_wr_en_out, output, 1 bit: FIFO write strobe.
REQ-012 The block SHALL have port fifo_data_out, output, DATA_WIDTH bits: FIFO write data.
REQ-013 The block SHALL have port grant_out, output, NUM_REQ bits: one-hot current grant, zero when none.
REQ-014 The block SHALL have port grant_id_out, output, $clog2(NUM_REQ) bits: index of current grantee, valid while grant_out is nonzero.
REQ-015 The block SHALL have port preempt_out, output, 1 bit: one-cycle pulse when a grant is revoked by stall timeout.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, GRANT and STALL.
REQ-017 In IDLE with any req_valid_in bit high, the FSM SHALL select the first valid index searching upward from (last_id+1) mod NUM_REQ, register grant_out and grant_id_out, clear burst_cnt and stall_cnt, and go to GRANT.
REQ-018 Grant SHALL appear on the cycle after valid is sampled in IDLE (1-cycle arbitration latency).
REQ-019 last_id SHALL update to the granted index when each grant is issued.
REQ-020 Combinationally, req_ready_out[g] SHALL equal (state==GRANT) & grant_out[g] & ~fifo_full_in; all other ready bits SHALL be 0.
REQ-021 A transfer SHALL occur when req_valid_in[g] & req_ready_out[g]; on a transfer, fifo_wr_en_out SHALL be 1 in the same cycle, and fifo_wr_en_out SHALL be 0 otherwise.
REQ-022 fifo_data_out SHALL combinationally carry the grantee's data slice while granted, and SHALL be 0 when no grant is held.
REQ-023 Each transfer SHALL increment burst_cnt (8-bit counter).
REQ-024 From GRANT, the FSM SHALL go to IDLE and clear grant_out when the transfer count reaches MAX_BURST, or when the grantee's valid is low in GRANT.
REQ-025 From GRANT with grantee valid high and fifo_full_in high, the FSM SHALL go to STALL with stall_cnt=1.
REQ-026 In STALL, ready SHALL be 0; if fifo_full_in is low the FSM SHALL return to GRANT and clear stall_cnt.
REQ-027 In STALL, if fifo_full_in is high the FSM SHALL increment stall_cnt; on reaching STALL_LIMIT it SHALL go to IDLE, clear grant_out and pulse preempt_out for one cycle.
REQ-028 When fifo_full_in and a release condition occur simultaneously, release SHALL take priority over STALL.
REQ-029 A requester dropping valid during STALL SHALL cause release to IDLE on the next edge without preempt_out.
REQ-030 The block SHALL make no write while fifo_full_in=1 under any state.
REQ-031 Requester data SHALL be passed unmodified and no word SHALL be duplicated or dropped.

Reset
REQ-032 While rst_in is high, the block SHALL hold state=IDLE, last_id=NUM_REQ-1 (first grant goes to index 0), grant_out=0, grant_id_out=0, burst_cnt=0, stall_cnt=0 and preempt_out=0, and outputs SHALL give fifo_wr_en_out=0, req_ready_out=0 and fifo_data_out=0.
REQ-033 Assertion of rst_in mid-burst SHALL abort immediately with no further writes; after deassertion, arbitration SHALL restart from index 0.

Verification
REQ-034 Bench scenario, single requester: req 2 valid with data 0xA0..0xA5 continuous, FIFO not full -> grant at cycle+1; writes 0xA0..0xA3; 1-cycle IDLE gap; new grant to req 2; writes 0xA4, 0xA5.
REQ-035 Bench scenario, round-robin: all 4 valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0; 4 writes each; 5 cycles per grant period.
REQ-036 Bench scenario, full stall: req 1 granted, fifo_full_in high for 3 cycles mid-burst -> STALL, ready=0, no writes; resumes with burst_cnt preserved and total 4 writes.
REQ-037 Bench scenario, preemption: fifo_full_in held high for 8 cycles while req 3 granted -> preempt_out pulses once; grant clears; next grant goes to index 0 if valid.
REQ-038 Bench scenario, reset mid-burst: rst_in asserted after 2 of 4 writes by req 1 -> fifo_wr_en_out=0 immediately; after release with reqs 0 and 1 valid -> first grant to 0.
REQ-039 Bench scenario, valid drop: req 0 deasserts valid after 2 transfers -> release to IDLE next edge; exactly 2 writes; preempt_out stays 0.
